// File: rtl/stream_decimator.sv
// Box-car decimator: averages each group of 2**LOG2_DECIM signed samples into one registered output.
// Optional macro STREAM_DECIM_ROUND_EN selects round-half-up with clamping instead of floor truncation.
module stream_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_DECIM = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  input  logic                  sync_clear
);

  localparam int DECIM = 2 ** LOG2_DECIM;
  // Phase needs at least one bit even when the group is a single sample.
  localparam int PW = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int AW = DATA_WIDTH + LOG2_DECIM;
  localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

  logic [PW-1:0]         phase;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  sum;
  logic [DATA_WIDTH-1:0] avg;
  logic                  last_slot;
  logic                  accept;

  always_comb begin
    last_slot    = (phase == LAST);
    // Only the group-closing sample waits on the output register.
    s_axis_ready = rst_n && !sync_clear && (!last_slot || !m_axis_valid || m_axis_ready);
    accept       = s_axis_valid && s_axis_ready;
    sum          = acc + AW'($signed(s_axis_data));
  end

`ifdef STREAM_DECIM_ROUND_EN
  generate
    if (LOG2_DECIM > 0) begin : g_round
      localparam logic signed [AW:0] BIAS = (AW+1)'(2 ** (LOG2_DECIM - 1));
      localparam logic signed [AW:0] MAXV = (AW+1)'(2 ** (DATA_WIDTH - 1) - 1);
      localparam logic signed [AW:0] MINV = (AW+1)'(-(2 ** (DATA_WIDTH - 1)));
      logic signed [AW:0] biased;
      logic signed [AW:0] shifted;
      always_comb begin
        biased  = (AW+1)'(sum) + BIAS;
        shifted = biased >>> LOG2_DECIM;
        if (shifted > MAXV)      avg = DATA_WIDTH'(MAXV);
        else if (shifted < MINV) avg = DATA_WIDTH'(MINV);
        else                     avg = DATA_WIDTH'(shifted);
      end
    end else begin : g_pass
      always_comb avg = DATA_WIDTH'(sum);
    end
  endgenerate
`else
  always_comb avg = DATA_WIDTH'(sum >>> LOG2_DECIM);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase        <= '0;
      acc          <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
    end else begin
      if (m_axis_valid && m_axis_ready) m_axis_valid <= 1'b0;
      if (sync_clear) begin
        phase <= '0;
        acc   <= '0;
      end else if (accept) begin
        if (last_slot) begin
          m_axis_data  <= avg;
          m_axis_valid <= 1'b1;
          phase        <= '0;
          acc          <= '0;
        end else begin
          phase <= phase + PW'(1);
          acc   <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_decimator.sv
// Self-checking bench for stream_decimator: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference of the group averaging.
module tb_stream_decimator;

  localparam int DW    = 16;
  localparam int L     = 2;
  localparam int DECIM = 1 << L;

`ifdef STREAM_DECIM_ROUND_EN
  localparam logic [DW-1:0] E1234 = 16'd3;
  localparam logic [DW-1:0] EM5   = 16'hFFFF;
  localparam logic [DW-1:0] E5678 = 16'd7;
`else
  localparam logic [DW-1:0] E1234 = 16'd2;
  localparam logic [DW-1:0] EM5   = 16'hFFFE;
  localparam logic [DW-1:0] E5678 = 16'd6;
`endif

  logic          clk;
  logic          rst_n;
  logic          s_axis_valid;
  logic          s_axis_ready;
  logic [DW-1:0] s_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic          sync_clear;

  stream_decimator #(.DATA_WIDTH(DW), .LOG2_DECIM(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_data  (s_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_data  (m_axis_data),
    .sync_clear   (sync_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: samples of the open group, plus the expected output register.
  int            grp[$];
  logic          ev = 1'b0;
  logic [DW-1:0] ed = '0;
  logic          rdy_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_avg(input int s);
    int r;
`ifdef STREAM_DECIM_ROUND_EN
    r = (s + (1 << (L - 1))) >>> L;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`else
    r = s >>> L;
`endif
    return DW'(r);
  endfunction

  // One clock: drive inputs, check ready, clock the model, then check the output register.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic mr,
                     input logic c, input logic r);
    logic exp_rdy;
    int   s;
    s_axis_valid = v;
    s_axis_data  = d;
    m_axis_ready = mr;
    sync_clear   = c;
    rst_n        = r;
    #1;
    exp_rdy  = r && !c && ((grp.size() != DECIM - 1) || !ev || mr);
    rdy_seen = s_axis_ready;
    check_eq("s_ready", {31'd0, s_axis_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (!r) begin
      grp.delete();
      ev = 1'b0;
      ed = '0;
    end else begin
      if (ev && mr) ev = 1'b0;
      if (c) grp.delete();
      else if (v && exp_rdy) begin
        grp.push_back(int'($signed(d)));
        if (grp.size() == DECIM) begin
          s = 0;
          foreach (grp[i]) s += grp[i];
          ed = ref_avg(s);
          ev = 1'b1;
          grp.delete();
        end
      end
    end
    #1;
    check_eq("m_valid", {31'd0, m_axis_valid}, {31'd0, ev});
    check_eq("m_data", {16'd0, m_axis_data}, {16'd0, ed});
    @(negedge clk);
  endtask

  task automatic send4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d, input logic mr);
    cyc(1'b1, a, mr, 1'b0, 1'b1);
    cyc(1'b1, b, mr, 1'b0, 1'b1);
    cyc(1'b1, c, mr, 1'b0, 1'b1);
    cyc(1'b1, d, mr, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    m_axis_ready = 1'b0;
    sync_clear   = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    do_reset();
    do_reset();
    check_eq("rst_valid", {31'd0, m_axis_valid}, 32'd0);
    check_eq("rst_data", {16'd0, m_axis_data}, 32'd0);

    // Basic averages and extremes.
    send4(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    check_eq("avg_1234", {16'd0, m_axis_data}, {16'd0, E1234});
    check_eq("avg_1234_v", {31'd0, m_axis_valid}, 32'd1);
    send4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
    check_eq("avg_m5", {16'd0, m_axis_data}, {16'd0, EM5});
    send4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    check_eq("avg_max", {16'd0, m_axis_data}, 32'h7FFF);
    send4(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
    check_eq("avg_min", {16'd0, m_axis_data}, 32'h8000);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Backpressure: first result held while the next group fills up to its last slot.
    send4(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
    cyc(1'b1, 16'd5, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'd6, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'd7, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'd8, 1'b0, 1'b0, 1'b1);
    check_eq("bp_stall_rdy", {31'd0, rdy_seen}, 32'd0);
    check_eq("bp_hold_data", {16'd0, m_axis_data}, {16'd0, E1234});
    cyc(1'b1, 16'd8, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'd8, 1'b1, 1'b0, 1'b1);
    check_eq("bp_release_rdy", {31'd0, rdy_seen}, 32'd1);
    check_eq("bp_second", {16'd0, m_axis_data}, {16'd0, E5678});
    check_eq("bp_second_v", {31'd0, m_axis_valid}, 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // sync_clear discards a partial group.
    cyc(1'b1, 16'd10, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'd20, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'd99, 1'b1, 1'b1, 1'b1);
    check_eq("clr_rdy", {31'd0, rdy_seen}, 32'd0);
    cyc(1'b1, 16'd4, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'd4, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'd4, 1'b1, 1'b0, 1'b1);
    check_eq("clr_no_early", {31'd0, m_axis_valid}, 32'd0);
    cyc(1'b1, 16'd4, 1'b1, 1'b0, 1'b1);
    check_eq("clr_out", {16'd0, m_axis_data}, 32'd4);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Reset at phase 2 with a result pending.
    send4(16'd9, 16'd9, 16'd9, 16'd9, 1'b0);
    cyc(1'b1, 16'd100, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'd100, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'd100, 1'b0, 1'b0, 1'b0);
    check_eq("rst_mid_v", {31'd0, m_axis_valid}, 32'd0);
    cyc(1'b1, 16'd8, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'd8, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'd8, 1'b1, 1'b0, 1'b1);
    check_eq("rst_mid_wait", {31'd0, m_axis_valid}, 32'd0);
    cyc(1'b1, 16'd8, 1'b1, 1'b0, 1'b1);
    check_eq("rst_mid_out", {16'd0, m_axis_data}, 32'd8);

    // Randomized traffic, occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 9) < 7,
          $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
